// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bist_pkg : shared types and the March C- element table for mem_bist_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int unsigned NUM_ELEMS = 6;
    localparam logic [2:0]  LAST_ELEM = 3'(NUM_ELEMS - 1);

    // Polarity bits: 0 selects the background, 1 its complement.
    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_pol;
        logic has_wr;
        logic wr_pol;
    } elem_desc_t;

    localparam elem_desc_t ELEM_TABLE [NUM_ELEMS] = '{
        '{down: 1'b0, has_rd: 1'b0, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b0},
        '{down: 1'b0, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1},
        '{down: 1'b0, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0},
        '{down: 1'b1, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1},
        '{down: 1'b1, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0},
        '{down: 1'b0, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b0, wr_pol: 1'b0}
    };

    function automatic elem_desc_t elem_desc(input logic [2:0] idx);
        elem_desc_t d;
        d = '0;
        if (idx <= LAST_ELEM) begin
            d = ELEM_TABLE[idx];
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bist_ctrl_if : single-port synchronous RAM access bus driven by the BIST
// Revision         : 1.0
// ---------------------------------------------------------------------------
interface mem_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bist_ctrl : March C- BIST sequencer with pipelined read-data compare
// Revision      : 1.0
// ---------------------------------------------------------------------------
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int MEM_DEPTH      = 16,
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start,
    input  wire logic                      abort,
    input  wire logic [DATA_WIDTH-1:0]     bg_pattern,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [MEM_ADDR_WIDTH-1:0]      fail_addr,
    output logic [2:0]                     fail_elem,
    output logic [3:0]                     fail_count,
    mem_bist_ctrl_if.master                mem
);

    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = MEM_ADDR_WIDTH'(1);

    state_t                    state, state_next;
    logic [2:0]                elem;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      phase;
    logic [DATA_WIDTH-1:0]     bg;

    logic                      cmp_valid;
    logic [DATA_WIDTH-1:0]     cmp_exp;
    logic [MEM_ADDR_WIDTH-1:0] cmp_addr;
    logic [2:0]                cmp_elem;

    elem_desc_t                desc;
    logic                      op_rd, op_wr;
    logic                      addr_done, elem_end;
    logic                      start_pass, abort_pass, finish_pass, pass_end;
    logic                      miscmp;
    logic [DATA_WIDTH-1:0]     rd_val, wr_val;

    assign desc      = elem_desc(elem);
    assign op_rd     = desc.has_rd && !phase;
    assign op_wr     = (state == ST_RUN) && !op_rd;
    // An address is finished once its last op (read-only, write-only or the write of a pair) issues.
    assign addr_done = !(desc.has_rd && desc.has_wr && !phase);
    assign elem_end  = addr_done && (desc.down ? (addr == '0) : (addr == ADDR_LAST));
    assign pass_end  = elem_end && (elem == LAST_ELEM);
    assign rd_val    = desc.rd_pol ? ~bg : bg;
    assign wr_val    = desc.wr_pol ? ~bg : bg;
    assign miscmp    = cmp_valid && (mem.mem_rdata != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_pass  = 1'b0;
        abort_pass  = 1'b0;
        finish_pass = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_RUN;
                    start_pass = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    abort_pass = 1'b1;
                end else if (pass_end) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next  = ST_IDLE;
                abort_pass  = abort;
                finish_pass = !abort;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem       <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            bg         <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
            cmp_valid  <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            cmp_elem   <= '0;
        end else begin
            cmp_valid <= (state == ST_RUN) && !abort && op_rd;
            if (op_rd) begin
                cmp_exp  <= rd_val;
                cmp_addr <= addr;
                cmp_elem <= elem;
            end

            if (start_pass) begin
                bg         <= bg_pattern;
                elem       <= '0;
                addr       <= '0;
                phase      <= 1'b0;
                done       <= 1'b0;
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_elem  <= '0;
                fail_count <= '0;
            end else begin
                if (abort_pass) begin
                    done <= 1'b0;
                end else if (finish_pass) begin
                    done <= 1'b1;
                end

                if (miscmp && !abort_pass) begin
                    fail <= 1'b1;
                    if (fail_count != 4'hF) begin
                        fail_count <= fail_count + 4'd1;
                    end
                    if (!fail) begin
                        fail_addr <= cmp_addr;
                        fail_elem <= cmp_elem;
                    end
                end

                // The counters freeze on the final op so mem_addr keeps the last address.
                if (state == ST_RUN && !abort && !pass_end) begin
                    if (!addr_done) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (elem_end) begin
                            elem <= elem + 3'd1;
                            addr <= elem_desc(elem + 3'd1).down ? ADDR_LAST : '0;
                        end else begin
                            addr <= desc.down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                        end
                    end
                end
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign mem.mem_en    = (state == ST_RUN);
    assign mem.mem_we    = op_wr;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = op_wr ? wr_val : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bist_ctrl : March C- op-stream and fault-report checks for mem_bist_ctrl
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_mem_bist_ctrl;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int NUM_OPS = 10 * DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] bg_pattern = '0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [3:0]    fail_count;

    int checks = 0;
    int failures = 0;

    mem_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    mem_bist_ctrl #(.MEM_DEPTH(DEPTH), .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bg_pattern (bg_pattern),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    // Fault-injectable RAM: stuck bits act on stored data, read_ff forces the read bus.
    logic          f_on = 1'b0;
    logic          f_read_ff = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_mask = '0;
    logic [DW-1:0] f_val = '0;
    logic [DW-1:0] ram [DEPTH];

    function automatic logic [DW-1:0] wfault(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (f_on && !f_read_ff && a == f_addr) return (d & ~f_mask) | (f_val & f_mask);
        return d;
    endfunction

    function automatic logic [DW-1:0] rfault(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (f_on && f_read_ff && a == f_addr) return 8'hFF;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_bus.mem_en) begin
            if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= wfault(mem_bus.mem_addr, mem_bus.mem_wdata);
            else                mem_bus.mem_rdata    <= rfault(mem_bus.mem_addr, ram[mem_bus.mem_addr]);
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    elem;
    } op_t;

    op_t ops[$];
    logic          exp_fail;
    logic [3:0]    exp_cnt;
    logic [AW-1:0] exp_faddr;
    logic [2:0]    exp_felem;

    // March C-: writes per element (-1 = none) and reads (-1 = none); 0 = bg, 1 = ~bg.
    task automatic build_ops(input logic [DW-1:0] bg);
        int rd_pol [6] = '{-1, 0, 1, 0, 1, 0};
        int wr_pol [6] = '{ 0, 1, 0, 1, 0, -1};
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                o.addr = AW'((e == 3 || e == 4) ? DEPTH - 1 - k : k);
                o.elem = 3'(e);
                if (rd_pol[e] >= 0) begin
                    o.we = 1'b0;
                    o.data = (rd_pol[e] == 1) ? ~bg : bg;
                    ops.push_back(o);
                end
                if (wr_pol[e] >= 0) begin
                    o.we = 1'b1;
                    o.data = (wr_pol[e] == 1) ? ~bg : bg;
                    ops.push_back(o);
                end
            end
        end
    endtask

    task automatic ref_results(input int n);
        logic [DW-1:0] rm [DEPTH];
        int cnt = 0;
        exp_fail = 1'b0; exp_faddr = '0; exp_felem = '0;
        for (int j = 0; j < n; j++) begin
            if (ops[j].we) begin
                rm[ops[j].addr] = wfault(ops[j].addr, ops[j].data);
            end else if (rfault(ops[j].addr, rm[ops[j].addr]) !== ops[j].data) begin
                if (!exp_fail) begin
                    exp_faddr = ops[j].addr;
                    exp_felem = ops[j].elem;
                end
                exp_fail = 1'b1;
                cnt++;
            end
        end
        exp_cnt = 4'((cnt > 15) ? 15 : cnt);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, ".fail"}, 32'(fail), 32'(exp_fail));
        check({tag, ".fail_count"}, 32'(fail_count), 32'(exp_cnt));
        check({tag, ".fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
        check({tag, ".fail_elem"}, 32'(fail_elem), 32'(exp_felem));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".fail"}, 32'(fail), 0);
        check({tag, ".fail_addr"}, 32'(fail_addr), 0);
        check({tag, ".fail_elem"}, 32'(fail_elem), 0);
        check({tag, ".fail_count"}, 32'(fail_count), 0);
        check({tag, ".mem_en"}, 32'(mem_bus.mem_en), 0);
        check({tag, ".mem_we"}, 32'(mem_bus.mem_we), 0);
        check({tag, ".mem_addr"}, 32'(mem_bus.mem_addr), 0);
        check({tag, ".mem_wdata"}, 32'(mem_bus.mem_wdata), 0);
    endtask

    // ev_kind: 0 none, 1 stray start, 2 abort, 3 reset; applied in op cycle ev_at.
    task automatic run_pass(input string tag, input logic [DW-1:0] bg, input int ev_kind, input int ev_at);
        int nwr = 0;
        int nrd = 0;
        build_ops(bg);
        @(negedge clk);
        bg_pattern = bg;
        start = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) bg_pattern = ~bg;
            check({tag, ".op_en"}, 32'(mem_bus.mem_en), 1);
            check({tag, ".op_busy"}, 32'(busy), 1);
            check({tag, ".op_done"}, 32'(done), 0);
            check({tag, ".op_we"}, 32'(mem_bus.mem_we), 32'(ops[i].we));
            check({tag, ".op_addr"}, 32'(mem_bus.mem_addr), 32'(ops[i].addr));
            check({tag, ".op_wdata"}, 32'(mem_bus.mem_wdata), ops[i].we ? 32'(ops[i].data) : 0);
            if (ops[i].we) nwr++; else nrd++;
            if (ev_kind == 1 && i == ev_at) begin
                start = 1'b1;
                bg_pattern = DW'($urandom);
            end
            if (ev_kind == 2 && i == ev_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                ref_results(ev_at - 1);
                check({tag, ".abort_busy"}, 32'(busy), 0);
                check({tag, ".abort_en"}, 32'(mem_bus.mem_en), 0);
                check({tag, ".abort_done"}, 32'(done), 0);
                check({tag, ".abort_addr_hold"}, 32'(mem_bus.mem_addr), 32'(ops[i].addr));
                check_result({tag, ".abort"});
                return;
            end
            if (ev_kind == 3 && i == ev_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, ".midreset"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        check({tag, ".writes"}, 32'(nwr), NUM_OPS / 2);
        check({tag, ".reads"}, 32'(nrd), NUM_OPS / 2);
        @(negedge clk);
        check({tag, ".chk_en"}, 32'(mem_bus.mem_en), 0);
        check({tag, ".chk_busy"}, 32'(busy), 1);
        check({tag, ".chk_done"}, 32'(done), 0);
        @(negedge clk);
        ref_results(NUM_OPS);
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".addr_hold"}, 32'(mem_bus.mem_addr), 32'(ops[NUM_OPS-1].addr));
        check_result(tag);
        @(negedge clk);
        check({tag, ".done_held"}, 32'(done), 1);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("after_reset");

        run_pass("clean_00", 8'h00, 0, 0);
        run_pass("clean_55", 8'h55, 0, 0);

        // abort and start together in IDLE: abort wins, done stays held
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort.busy", 32'(busy), 0);
        check("idle_abort.en", 32'(mem_bus.mem_en), 0);
        check("idle_abort.done", 32'(done), 1);

        f_on = 1'b1; f_read_ff = 1'b0; f_addr = 4'd5; f_mask = 8'h08; f_val = 8'h00;
        run_pass("sa0_a5b3", 8'h00, 0, 0);
        check("sa0_a5b3.fixed_addr", 32'(fail_addr), 5);
        check("sa0_a5b3.fixed_elem", 32'(fail_elem), 2);
        check("sa0_a5b3.fixed_cnt", 32'(fail_count), 2);

        f_read_ff = 1'b1; f_addr = 4'd9;
        run_pass("ff_a9", 8'h00, 0, 0);
        check("ff_a9.fixed_addr", 32'(fail_addr), 9);
        check("ff_a9.fixed_elem", 32'(fail_elem), 1);
        check("ff_a9.fixed_cnt", 32'(fail_count), 3);

        run_pass("abort50", DW'($urandom), 2, 50);
        f_on = 1'b0;
        run_pass("after_abort", DW'($urandom), 0, 0);
        run_pass("stray_start", DW'($urandom), 1, 20);
        run_pass("reset70", DW'($urandom), 3, 70);
        run_pass("after_reset70", DW'($urandom), 0, 0);

        for (int r = 0; r < 4; r++) begin
            f_on = 1'b1;
            f_read_ff = 1'($urandom_range(0, 1));
            f_addr = AW'($urandom_range(0, DEPTH - 1));
            f_mask = DW'($urandom_range(1, 255));
            f_val = DW'($urandom);
            run_pass("random_fault", DW'($urandom), 0, 0);
        end
        f_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- March C- built-in self-test sequencer for the factory-test scratch memory (MEM_DEPTH words, synchronous 1-cycle-read RAM).
- Owns the memory port for a full test pass and compares read data against expected values.
- Reports pass/fail, first failing address/element and a saturating error count to the factory-test top-level for output on uo_out/uio.

Parameters:
MEM_DEPTH, 16, number of words tested; must be ≤ 2^MEM_ADDR_WIDTH
MEM_ADDR_WIDTH, 4, address width
DATA_WIDTH, 8, memory word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a test pass (sampled only in IDLE)
abort  in  1  synchronous abort of a running pass
bg_pattern  in  DATA_WIDTH  background value "0"; "1" = ~bg_pattern; captured on start
busy  out  1  pass in progress
done  out  1  pass completed; held until next start
fail  out  1  sticky miscompare flag for current/last pass
fail_addr  out  MEM_ADDR_WIDTH  address of first miscompare
fail_elem  out  3  march element (0-5) of first miscompare
fail_count  out  4  miscompare count, saturates at 15
mem_en  out  1  memory access strobe
mem_we  out  1  write enable (valid when mem_en)
mem_addr  out  MEM_ADDR_WIDTH  access address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid cycle after a read

Behaviour:
- Reset: all outputs 0; FSM in IDLE; captured background 0.
- States: IDLE, RUN, CHECK. done/fail are registers, not states.
- IDLE + start=1 + abort=0 at an edge: go to RUN, busy=1, done=0, fail=0, fail_count=0, fail_addr=0, fail_elem=0, capture bg_pattern. The first op is presented in the following cycle.
- March elements, where 0=bg and 1=~bg:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- Addressing: ⇑ runs 0→MEM_DEPTH-1; ⇓ runs MEM_DEPTH-1→0.
- One memory op per cycle, mem_en=1 throughout RUN, no idle cycles between elements.
  - Read-write pairs: read at addr in cycle t; write to the same addr in t+1.
- Compare: mem_rdata is checked in the cycle after each read against the expected value registered with that read (pipelined expected/addr/elem). A mismatch increments fail_count (saturating at 15) and sets fail. On the first mismatch only, it also captures fail_addr and fail_elem.
- Op count: 10·MEM_DEPTH (160 at default). After the final E5 read, go to CHECK, where mem_en=0 and the last compare happens. Next edge → IDLE with busy=0, done=1.
- Timing: done rises 10·MEM_DEPTH+1 edges after the start edge (161 at default).
- start while busy: ignored.
- abort=1 in RUN or CHECK: next edge → IDLE, busy=0, mem_en=0, done=0. fail/fail_count/fail_addr hold their values. A compare pending at the abort edge is discarded.
- abort and start both high in IDLE: abort wins, stay IDLE.
- rst_n low mid-pass: immediate return to reset values. The memory contents are undefined.
- mem_wdata is 0 when mem_we=0.
- mem_addr holds its last value when mem_en=0.

Decomposition:
- Package mem_bist_pkg:
  - state enum
  - element count constant (6)
  - element descriptor table (direction, read?, expected polarity, write polarity)
  - function returning the descriptor for an element index
- No sub-module. The compare pipeline stays inline (~1 stage).

Test Plan:
- Fault-free RAM model, bg_pattern=0x00, start pulse → mem_en high 160 cycles, 80 writes, 80 reads; done=1 at edge 161; fail=0, fail_count=0.
- bg_pattern=0x55 → E0 writes 0x55 to addr 0..15; E1 writes 0xAA; E3 first access is a read at addr 15; pass clean.
- RAM model with addr 5 bit 3 stuck-at-0, bg=0x00 → fail=1, fail_addr=5, fail_elem=2, fail_count=2, done=1 at 161.
- RAM model where addr 9 always returns 0xFF, bg=0x00 → fail_elem=1, fail_addr=9, fail_count=3 (E1, E3, E5).
- abort asserted at cycle 50 → next cycle busy=0, mem_en=0, done=0. Then start again → full clean pass, done at 161 edges after restart.
- start pulsed at cycle 20 of a running pass → no effect, done still at 161. rst_n pulled low at cycle 70 → all outputs 0 immediately, and the next start runs normally.
